// File: rtl/issue_scoreboard.sv
// Dual-slot in-order issue scoreboard: one pending-write bit per register,
// RAW/WAW issue gating for an older slot A and younger slot B, plus a drain handshake.
module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                validA_i,
  input  logic                pReadA_i,
  input  logic                sReadA_i,
  input  logic                pWriteA_i,
  input  logic [ADDR_W-1:0]   primRegA_i,
  input  logic [ADDR_W-1:0]   secRegA_i,
  input  logic                validB_i,
  input  logic                pReadB_i,
  input  logic                sReadB_i,
  input  logic                pWriteB_i,
  input  logic [ADDR_W-1:0]   primRegB_i,
  input  logic [ADDR_W-1:0]   secRegB_i,
  output logic                issueA_o,
  output logic                issueB_o,
  input  logic                wbA_i,
  input  logic [ADDR_W-1:0]   wbAddrA_i,
  input  logic                wbB_i,
  input  logic [ADDR_W-1:0]   wbAddrB_i,
  input  logic                drain_i,
  output logic                drained_o,
  output logic                busy_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [CNT_W-1:0]    stallCount_o,
  output logic                error_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state, stateNext;
  logic [NUM_REGS-1:0] pend, pendNext, setVec, clrVec;
  logic [CNT_W-1:0]    stallCount;
  logic                errorFlag;
  logic                runState, hazA, hazB, intraB, stallEvent, wbError;

  // Issue is gated by reset so nothing leaves the scoreboard while reset is held.
  assign runState = reset_i && (state == RUN);

  // Hazards look only at the registered vector, so a same-cycle writeback costs one cycle.
  assign hazA = (pReadA_i  && pend[primRegA_i]) ||
                (sReadA_i  && pend[secRegA_i])  ||
                (pWriteA_i && pend[primRegA_i]);
  assign hazB = (pReadB_i  && pend[primRegB_i]) ||
                (sReadB_i  && pend[secRegB_i])  ||
                (pWriteB_i && pend[primRegB_i]);

  assign intraB = pWriteA_i && validA_i &&
                  ((pReadB_i  && (primRegB_i == primRegA_i)) ||
                   (sReadB_i  && (secRegB_i  == primRegA_i)) ||
                   (pWriteB_i && (primRegB_i == primRegA_i)));

  assign issueA_o = runState && validA_i && !hazA;
  assign issueB_o = runState && validB_i && !hazB && !intraB && (issueA_o || !validA_i);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    setVec = '0;
    clrVec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wbA_i && (wbAddrA_i == ADDR_W'(i)))               clrVec[i] = 1'b1;
      if (wbB_i && (wbAddrB_i == ADDR_W'(i)))               clrVec[i] = 1'b1;
      if (issueA_o && pWriteA_i && (primRegA_i == ADDR_W'(i))) setVec[i] = 1'b1;
      if (issueB_o && pWriteB_i && (primRegB_i == ADDR_W'(i))) setVec[i] = 1'b1;
    end
  end

  // Set is applied after clear so a colliding set wins.
  assign pendNext   = (pend & ~clrVec) | setVec;
  assign wbError    = (wbA_i && !pend[wbAddrA_i]) || (wbB_i && !pend[wbAddrB_i]);
  assign stallEvent = (validA_i && !issueA_o) || (validB_i && !issueB_o);

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (drain_i) stateNext = DRAIN;
      DRAIN:   if (pend == '0) stateNext = DONE;
      DONE:    stateNext = RUN;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_i) begin
      state      <= RUN;
      pend       <= '0;
      stallCount <= '0;
      errorFlag  <= 1'b0;
    end else begin
      state <= stateNext;
      pend  <= pendNext;
      if (stallEvent && (stallCount != '1)) stallCount <= stallCount + 1'b1;
      if (wbError) errorFlag <= 1'b1;
    end
  end

  assign busy_o       = (state != RUN);
  assign drained_o    = (state == DONE);
  assign pending_o    = pend;
  assign stallCount_o = stallCount;
  assign error_o      = errorFlag;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus randomized
// traffic, all compared against an array-based model of the scoreboard rules.
module tb_issue_scoreboard;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic          validA, pReadA, sReadA, pWriteA, validB, pReadB, sReadB, pWriteB;
  logic [AW-1:0] primA, secA, primB, secB, wbAddrA, wbAddrB;
  logic          wbA, wbB, drain;
  logic          issueA_o, issueB_o, drained_o, busy_o, error_o;
  logic [NR-1:0] pending_o;
  logic [CW-1:0] stallCount_o;

  // Reference model: mode 0 = running, 1 = draining, 2 = drain complete.
  bit mPend[NR];
  int mMode, mStall;
  bit mErr;
  int nChecks = 0, nErrors = 0;
  bit gotA, gotB, gotDrained;

  issue_scoreboard #(.NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .validA_i(validA), .pReadA_i(pReadA), .sReadA_i(sReadA), .pWriteA_i(pWriteA),
    .primRegA_i(primA), .secRegA_i(secA),
    .validB_i(validB), .pReadB_i(pReadB), .sReadB_i(sReadB), .pWriteB_i(pWriteB),
    .primRegB_i(primB), .secRegB_i(secB),
    .issueA_o(issueA_o), .issueB_o(issueB_o),
    .wbA_i(wbA), .wbAddrA_i(wbAddrA), .wbB_i(wbB), .wbAddrB_i(wbAddrB),
    .drain_i(drain), .drained_o(drained_o), .busy_o(busy_o),
    .pending_o(pending_o), .stallCount_o(stallCount_o), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic idle();
    validA = 0; pReadA = 0; sReadA = 0; pWriteA = 0; primA = '0; secA = '0;
    validB = 0; pReadB = 0; sReadB = 0; pWriteB = 0; primB = '0; secB = '0;
    wbA = 0; wbAddrA = '0; wbB = 0; wbAddrB = '0; drain = 0;
  endtask

  task automatic modelReset();
    foreach (mPend[i]) mPend[i] = 0;
    mMode = 0; mStall = 0; mErr = 0;
  endtask

  function automatic logic [NR-1:0] modelVec();
    logic [NR-1:0] v = '0;
    foreach (mPend[i]) v[i] = mPend[i];
    return v;
  endfunction

  // One clock cycle: inputs are already driven just after a falling edge.
  task automatic tick();
    bit hA, hB, iB, eA, eB, allZero;
    #1;
    hA = (pReadA && mPend[primA]) || (sReadA && mPend[secA]) || (pWriteA && mPend[primA]);
    hB = (pReadB && mPend[primB]) || (sReadB && mPend[secB]) || (pWriteB && mPend[primB]);
    iB = pWriteA && validA && ((pReadB && primB == primA) || (sReadB && secB == primA) ||
                               (pWriteB && primB == primA));
    eA = (mMode == 0) && validA && !hA;
    eB = (mMode == 0) && validB && !hB && !iB && (eA || !validA);
    gotA = issueA_o; gotB = issueB_o; gotDrained = drained_o;
    nChecks++;
    if (issueA_o !== eA) begin nErrors++; $display("FAIL issueA got=%b exp=%b t=%0t", issueA_o, eA, $time); end
    nChecks++;
    if (issueB_o !== eB) begin nErrors++; $display("FAIL issueB got=%b exp=%b t=%0t", issueB_o, eB, $time); end
    nChecks++;
    if (busy_o !== (mMode != 0)) begin nErrors++; $display("FAIL busy got=%b exp=%b t=%0t", busy_o, mMode != 0, $time); end
    nChecks++;
    if (drained_o !== (mMode == 2)) begin nErrors++; $display("FAIL drained got=%b exp=%b t=%0t", drained_o, mMode == 2, $time); end

    allZero = (modelVec() == '0);
    if (wbA && !mPend[wbAddrA]) mErr = 1;
    if (wbB && !mPend[wbAddrB]) mErr = 1;
    if (wbA) mPend[wbAddrA] = 0;
    if (wbB) mPend[wbAddrB] = 0;
    if (eA && pWriteA) mPend[primA] = 1;
    if (eB && pWriteB) mPend[primB] = 1;
    if (((validA && !eA) || (validB && !eB)) && mStall < 65535) mStall++;
    case (mMode)
      0: if (drain) mMode = 1;
      1: if (allZero) mMode = 2;
      default: mMode = 0;
    endcase

    @(posedge clock_i); #1;
    nChecks++;
    if (pending_o !== modelVec()) begin nErrors++; $display("FAIL pending got=%h exp=%h t=%0t", pending_o, modelVec(), $time); end
    nChecks++;
    if (stallCount_o !== CW'(mStall)) begin nErrors++; $display("FAIL stallCount got=%0d exp=%0d t=%0t", stallCount_o, mStall, $time); end
    nChecks++;
    if (error_o !== mErr) begin nErrors++; $display("FAIL error got=%b exp=%b t=%0t", error_o, mErr, $time); end
    @(negedge clock_i);
  endtask

  task automatic applyReset();
    @(negedge clock_i);
    idle();
    reset_i = 0;
    modelReset();
    @(negedge clock_i);
    reset_i = 1;
  endtask

  task automatic test_reset();
    idle();
    reset_i = 0;
    validA = 1; pWriteA = 1; primA = 5'd2; validB = 1; pReadB = 1; primB = 5'd9;
    #12;
    nChecks++;
    if (issueA_o !== 0 || issueB_o !== 0) begin nErrors++; $display("FAIL reset_issue got=%b%b exp=00", issueA_o, issueB_o); end
    nChecks++;
    if (pending_o !== '0 || stallCount_o !== '0 || error_o !== 0 || busy_o !== 0 || drained_o !== 0) begin
      nErrors++; $display("FAIL reset_state pend=%h stall=%0d err=%b busy=%b drained=%b", pending_o, stallCount_o, error_o, busy_o, drained_o);
    end
    modelReset();
    @(negedge clock_i);
    idle();
    reset_i = 1;
  endtask

  task automatic test_intra_slot();
    validA = 1; pWriteA = 1; primA = 5'd3;
    validB = 1; pReadB = 1; primB = 5'd3;
    tick();
    nChecks++;
    if (gotA !== 1 || gotB !== 0) begin nErrors++; $display("FAIL intra_issue got=%b%b exp=10", gotA, gotB); end
    nChecks++;
    if (pending_o !== 32'h0000_0008 || stallCount_o !== 16'd1) begin
      nErrors++; $display("FAIL intra_state pend=%h stall=%0d exp=00000008/1", pending_o, stallCount_o);
    end
    idle();
  endtask

  task automatic test_same_cycle_wb();
    validA = 1; pReadA = 1; primA = 5'd3; wbA = 1; wbAddrA = 5'd3;
    tick();
    nChecks++;
    if (gotA !== 0 || pending_o !== '0) begin nErrors++; $display("FAIL samecycle_wb issueA=%b pend=%h exp=0/0", gotA, pending_o); end
    wbA = 0;
    tick();
    nChecks++;
    if (gotA !== 1) begin nErrors++; $display("FAIL represent issueA=%b exp=1", gotA); end
    idle();
  endtask

  task automatic test_stall_independent();
    int s0;
    validA = 1; pWriteA = 1; primA = 5'd5;
    tick();
    idle();
    s0 = int'(stallCount_o);
    validA = 1; pReadA = 1; primA = 5'd5;
    validB = 1; pWriteB = 1; primB = 5'd7;
    for (int i = 0; i < 3; i++) tick();
    nChecks++;
    if (stallCount_o !== CW'(s0 + 3)) begin nErrors++; $display("FAIL stall_incr got=%0d exp=%0d", stallCount_o, s0 + 3); end
    wbA = 1; wbAddrA = 5'd5;
    tick();
    wbA = 0;
    tick();
    nChecks++;
    if (gotA !== 1 || gotB !== 1 || pending_o !== 32'h0000_0080) begin
      nErrors++; $display("FAIL dual_issue got=%b%b pend=%h exp=11/00000080", gotA, gotB, pending_o);
    end
    idle();
    wbB = 1; wbAddrB = 5'd7;
    tick();
    idle();
  endtask

  task automatic test_drain();
    int pulses = 0;
    validA = 1; pWriteA = 1; primA = 5'd1;
    validB = 1; pWriteB = 1; primB = 5'd2;
    tick();
    idle();
    drain = 1;
    tick();
    drain = 0;
    validA = 1; pWriteA = 1; primA = 5'd20; wbA = 1; wbAddrA = 5'd1;
    tick(); pulses += int'(gotDrained);
    nChecks++;
    if (gotA !== 0 || busy_o !== 1) begin nErrors++; $display("FAIL drain_block issueA=%b busy=%b exp=0/1", gotA, busy_o); end
    idle();
    validA = 1; pWriteA = 1; primA = 5'd20;
    drain = 1;
    tick(); pulses += int'(gotDrained);
    idle();
    wbB = 1; wbAddrB = 5'd2;
    tick(); pulses += int'(gotDrained);
    idle();
    for (int i = 0; i < 6; i++) begin tick(); pulses += int'(gotDrained); end
    nChecks++;
    if (pulses != 1 || busy_o !== 0) begin nErrors++; $display("FAIL drain_pulse count=%0d busy=%b exp=1/0", pulses, busy_o); end
  endtask

  task automatic test_error();
    wbA = 1; wbAddrA = 5'd9;
    tick();
    nChecks++;
    if (error_o !== 1 || pending_o !== '0) begin nErrors++; $display("FAIL wb_nonpending err=%b pend=%h exp=1/0", error_o, pending_o); end
    idle();
    validA = 1; pWriteA = 1; primA = 5'd4;
    tick();
    idle();
    wbA = 1; wbAddrA = 5'd4; wbB = 1; wbAddrB = 5'd4;
    tick();
    nChecks++;
    if (pending_o !== '0 || error_o !== 1) begin nErrors++; $display("FAIL dual_wb pend=%h err=%b exp=0/1", pending_o, error_o); end
    idle();
  endtask

  task automatic test_random();
    int q[$];
    for (int n = 0; n < 1500; n++) begin
      validA = 1'($urandom); pReadA = 1'($urandom); sReadA = 1'($urandom); pWriteA = 1'($urandom);
      primA = AW'($urandom_range(7)); secA = AW'($urandom_range(7));
      validB = 1'($urandom); pReadB = 1'($urandom); sReadB = 1'($urandom); pWriteB = 1'($urandom);
      primB = AW'($urandom_range(7)); secB = AW'($urandom_range(7));
      q.delete();
      foreach (mPend[i]) if (mPend[i]) q.push_back(i);
      wbA = ($urandom_range(3) == 0); wbB = ($urandom_range(3) == 0);
      wbAddrA = (q.size() > 0 && $urandom_range(9) != 0) ? AW'(q[$urandom_range(q.size() - 1)]) : AW'($urandom_range(7));
      wbAddrB = (q.size() > 0 && $urandom_range(9) != 0) ? AW'(q[$urandom_range(q.size() - 1)]) : AW'($urandom_range(7));
      drain = ($urandom_range(15) == 0);
      tick();
    end
    idle();
  endtask

  task automatic test_saturation_and_reset();
    validA = 1; pWriteA = 1; primA = 5'd5;
    tick();
    idle();
    validA = 1; pReadA = 1; primA = 5'd5;
    for (int n = 0; n < 65534; n++) @(posedge clock_i);
    #1;
    nChecks++;
    if (stallCount_o !== 16'hFFFE) begin nErrors++; $display("FAIL stall_presat got=%h exp=fffe", stallCount_o); end
    for (int n = 0; n < 7; n++) @(posedge clock_i);
    #1;
    nChecks++;
    if (stallCount_o !== 16'hFFFF) begin nErrors++; $display("FAIL stall_sat got=%h exp=ffff", stallCount_o); end
    mStall = 65535;
    @(negedge clock_i);
    drain = 1;
    tick();
    drain = 0;
    validA = 1; pWriteA = 1; primA = 5'd10; pReadA = 0;
    #2 reset_i = 0;
    #1;
    nChecks++;
    if (pending_o !== '0 || stallCount_o !== '0 || error_o !== 0 || busy_o !== 0 ||
        drained_o !== 0 || issueA_o !== 0) begin
      nErrors++; $display("FAIL async_reset pend=%h stall=%0d err=%b busy=%b drained=%b issueA=%b",
                          pending_o, stallCount_o, error_o, busy_o, drained_o, issueA_o);
    end
    modelReset();
    @(negedge clock_i);
    idle();
    reset_i = 1;
    wbA = 1; wbAddrA = 5'd5;
    tick();
    nChecks++;
    if (error_o !== 1) begin nErrors++; $display("FAIL late_wb err=%b exp=1", error_o); end
    idle();
  endtask

  initial begin
    test_reset();
    @(negedge clock_i);
    test_intra_slot();
    test_same_cycle_wb();
    test_stall_independent();
    test_drain();
    test_error();
    applyReset();
    test_random();
    applyReset();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
